// File: rtl/accel_pkg.sv
// Shared accelerator definitions: vertex word width/type and the triangle
// assembler state encoding.
package accel_pkg;

   localparam int DBITS_DEF = 96;

   typedef logic [DBITS_DEF-1:0] vertex_t;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } asm_state_e;

endpackage : accel_pkg

// File: rtl/triangle_assembler.sv
// Collects three consecutive vertices from a first-word-fall-through FIFO and
// presents them as one triangle with a valid/ready handshake.
module triangle_assembler
   import accel_pkg::*;
#(
   parameter int DBITS = DBITS_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fifo_empty,
   input  logic [DBITS-1:0] fifo_dout,
   output logic             fifo_rd,
   input  logic             abort,
   output logic             tri_valid,
   input  logic             tri_ready,
   output logic [DBITS-1:0] tri_v0,
   output logic [DBITS-1:0] tri_v1,
   output logic [DBITS-1:0] tri_v2,
   output logic [15:0]      tri_count
);

   asm_state_e       state_q;
   logic [1:0]       idx_q;
   logic [DBITS-1:0] v0_q, v1_q, v2_q;
   logic             tri_valid_q;
   logic [15:0]      tri_count_q;
   logic [15:0]      tri_count_d;

   // Pop only while collecting; gating with reset keeps the FIFO untouched
   // for the whole time reset is held, not just after the first edge.
   assign fifo_rd = reset && (state_q == COLLECT) && !fifo_empty && !abort;

   // NOTE: combinational next-state gets its default on the first line so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      tri_count_d = tri_count_q;
      if (tri_valid_q && tri_ready) begin
         tri_count_d = tri_count_q + 16'd1;
      end
   end

   // NOTE: the vertex slots are ordinary flops, not a memory, so resetting
   // them to zero is cheap and gives defined outputs straight out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= COLLECT;
         idx_q       <= 2'd0;
         v0_q        <= '0;
         v1_q        <= '0;
         v2_q        <= '0;
         tri_valid_q <= 1'b0;
         tri_count_q <= 16'd0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         tri_count_q <= tri_count_d;
         case (state_q)
            COLLECT: begin
               if (abort) begin
                  idx_q <= 2'd0;
               end else if (!fifo_empty) begin
                  case (idx_q)
                     2'd0:    v0_q <= fifo_dout;
                     2'd1:    v1_q <= fifo_dout;
                     default: v2_q <= fifo_dout;
                  endcase
                  if (idx_q == 2'd2) begin
                     idx_q       <= 2'd0;
                     state_q     <= PRESENT;
                     tri_valid_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end
            end
            PRESENT: begin
               // Abort is deliberately ignored here: a presented triangle stays.
               if (tri_ready) begin
                  state_q     <= COLLECT;
                  tri_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= COLLECT;
               idx_q   <= 2'd0;
            end
         endcase
      end
   end

   assign tri_valid = tri_valid_q;
   assign tri_v0    = v0_q;
   assign tri_v1    = v1_q;
   assign tri_v2    = v2_q;
   assign tri_count = tri_count_q;

endmodule : triangle_assembler

// File: doc/triangle_assembler.md
TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 Parameter: DBITS, default 96, width of one vertex word (3 x 32-bit coordinates).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: fifo_empty  input  1  vertex FIFO holds no entries.
REQ-005 Port: fifo_dout  input  DBITS  head entry of vertex FIFO; first-word-fall-through, valid whenever fifo_empty=0.
REQ-006 Port: fifo_rd  output  1  pop request to vertex FIFO.
REQ-007 Port: abort  input  1  synchronous discard of a partially collected triangle.
REQ-008 Port: tri_valid  output  1  a complete triangle is presented.
REQ-009 Port: tri_ready  input  1  downstream rasterizer accepts the triangle.
REQ-010 Port: tri_v0, tri_v1, tri_v2  output  DBITS each  triangle vertices, in FIFO order.
REQ-011 Port: tri_count  output  16  number of triangles accepted since reset.

Function
REQ-012 States SHALL be COLLECT and PRESENT; reset state SHALL be COLLECT with vertex index 0.
REQ-013 In COLLECT, fifo_rd SHALL equal !fifo_empty && !abort, combinationally; fifo_rd SHALL never be 1 while fifo_empty=1 or in PRESENT.
REQ-014 On each COLLECT cycle with fifo_rd=1, fifo_dout SHALL be registered into slot tri_v[index], and index SHALL advance 0->1->2.
REQ-015 The pop at index 2 SHALL move the state to PRESENT and set tri_valid=1 on the next cycle; minimum latency from the first pop to tri_valid is 3 cycles.
REQ-016 In PRESENT, tri_valid, tri_v0..2 SHALL hold stable until a cycle with tri_ready=1.
REQ-017 Handshake cycle (tri_valid=1 && tri_ready=1): next cycle tri_valid=0, state COLLECT, index 0, tri_count incremented.
REQ-018 No FIFO pop SHALL occur in the handshake cycle; one bubble cycle per triangle is required behaviour.
REQ-019 tri_count SHALL wrap 16'hFFFF -> 16'h0000 without any other effect.
REQ-020 abort=1 in COLLECT SHALL reset index to 0 next cycle, suppress fifo_rd that cycle, and leave slot contents unchanged.
REQ-021 abort in PRESENT SHALL be ignored; the presented triangle is never withdrawn.
REQ-022 fifo_empty=1 mid-triangle SHALL stall with index held; collection resumes on the next non-empty cycle.
REQ-023 tri_ready while tri_valid=0 SHALL be ignored.

Reset
REQ-024 reset=0 SHALL asynchronously force state COLLECT, index 0, tri_valid 0, tri_count 0, tri_v0..2 all zero.
REQ-025 reset asserted mid-triangle or in PRESENT SHALL discard the partial or presented triangle without incrementing tri_count.
REQ-026 fifo_rd SHALL be 0 throughout reset assertion.

Structure
REQ-027 Shared package accel_pkg SHALL hold the DBITS default constant, the vertex word typedef, and the assembler state enum.
REQ-028 The block SHALL be a single module with no sub-modules; it connects directly to the existing vertex FIFO's empty, dout and rd ports.
REQ-029 All outputs except fifo_rd SHALL be driven from registers.

Verification
REQ-030 FIFO preloaded with A, B, C; tri_ready=1 -> fifo_rd high 3 consecutive cycles, tri_valid=1 with v0=A, v1=B, v2=C, tri_count 0->1.
REQ-031 Triangle presented, tri_ready=0 for 5 cycles -> tri_valid and vertices stable, zero pops; tri_ready=1 -> accepted, count +1.
REQ-032 Push A, B, then 4 empty cycles, then C -> no pop while empty, index held at 2, triangle {A,B,C} emitted.
REQ-033 Pop A, B, assert abort one cycle, then push D, E, F -> triangle {D,E,F}; A and B never emitted.
REQ-034 tri_count forced to 16'hFFFF, one triangle accepted -> tri_count=16'h0000.
REQ-035 Reset asserted while PRESENT -> tri_valid=0 immediately (asynchronous), fifo_rd=0, count 0; after release, the next three FIFO entries form the next triangle.
